fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue between imem and decode; flushes on redirect.
// Define FETCHQ_BYPASS_EN to forward a response straight to the decode outputs when the queue is empty.

module fetch_queue_chk #(
  parameter int PTR_W  = 3,
  parameter int DROP_W = 4,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             imem_valid,
  input logic [PTR_W-1:0] alloc,
  input logic [PTR_W-1:0] fill,
  input logic [PTR_W-1:0] head,
  input logic [DROP_W-1:0] drop
);
  logic [PTR_W-1:0] pending_s;
  logic [PTR_W-1:0] occ_s;

  assign pending_s = alloc - fill;
  assign occ_s     = alloc - head;

  a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    imem_valid |-> (pending_s != '0 || drop != '0));

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ_s <= PTR_W'(DEPTH));
endmodule

module fetch_queue #(
  parameter int              DEPTH  = 4,
  parameter int              ADDR_W = 16,
  parameter int              XLEN   = 32,
  parameter logic [XLEN-1:0] BOOT   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic [ADDR_W-1:0]            imem_addr,
  output logic                         imem_oe,
  input  logic                         imem_ready,
  input  logic [31:0]                  imem_rdata,
  input  logic                         imem_valid,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [XLEN-1:0]              inst_pc,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int DROP_W = $clog2(2*DEPTH) + 1;
  localparam int OCC_W  = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  alloc_r, fill_r, head_r;
  logic [DROP_W-1:0] drop_r;
  logic [XLEN-1:0]   fpc_r;
  logic [XLEN-1:0]   pc_mem_r   [DEPTH];
  logic [31:0]       inst_mem_r [DEPTH];

  logic [PTR_W-1:0]  occ_s, pend_s;
  logic [DROP_W-1:0] in_use_s;
  logic              drop_zero_s, empty_s, fire_s, fill_s, discard_s, consume_s;
  logic [IDX_W-1:0]  head_idx_s;

  assign occ_s       = alloc_r - head_r;
  assign pend_s      = alloc_r - fill_r;
  assign in_use_s    = DROP_W'(occ_s) + drop_r;
  assign drop_zero_s = (drop_r == '0);
  assign empty_s     = (head_r == fill_r);
  assign head_idx_s  = head_r[IDX_W-1:0];

  // Stale responses are counted in in_use_s so drop can never exceed DEPTH.
  assign imem_oe   = rst_n && !redirect && (in_use_s < DROP_W'(DEPTH));
  assign imem_addr = fpc_r[ADDR_W-1:0];
  assign fire_s    = imem_oe && imem_ready;
  assign fill_s    = imem_valid && !redirect && drop_zero_s;
  assign discard_s = imem_valid && !redirect && !drop_zero_s;
  assign occupancy = OCC_W'(occ_s);
  assign inst_pc   = pc_mem_r[head_idx_s];

`ifdef FETCHQ_BYPASS_EN
  logic byp_s;
  assign byp_s      = rst_n && empty_s && imem_valid && drop_zero_s;
  assign inst_valid = !empty_s || byp_s;
  assign inst       = byp_s ? imem_rdata : inst_mem_r[head_idx_s];
`else
  assign inst_valid = !empty_s;
  assign inst       = inst_mem_r[head_idx_s];
`endif

  assign consume_s = inst_valid && inst_ready && !redirect;

  // Pointer, drop counter, fetch PC and entry storage update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_r <= '0;
      fill_r  <= '0;
      head_r  <= '0;
      drop_r  <= '0;
      fpc_r   <= BOOT;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= '0;
        inst_mem_r[i] <= 32'h0;
      end
    end else if (redirect) begin
      fpc_r  <= redirect_pc & {{(XLEN-1){1'b1}}, 1'b0};
      head_r <= alloc_r;
      fill_r <= alloc_r;
      drop_r <= drop_r + DROP_W'(pend_s) - DROP_W'(imem_valid);
    end else begin
      if (fire_s) begin
        pc_mem_r[alloc_r[IDX_W-1:0]] <= fpc_r;
        alloc_r <= alloc_r + PTR_W'(1);
        fpc_r   <= fpc_r + XLEN'(32'd4);
      end
      if (fill_s) begin
        inst_mem_r[fill_r[IDX_W-1:0]] <= imem_rdata;
        fill_r <= fill_r + PTR_W'(1);
      end
      if (discard_s) begin
        drop_r <= drop_r - DROP_W'(1);
      end
      if (consume_s) begin
        head_r <= head_r + PTR_W'(1);
      end
    end
  end

  fetch_queue_chk #(.PTR_W(PTR_W), .DROP_W(DROP_W), .DEPTH(DEPTH)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_valid (imem_valid),
    .alloc      (alloc_r),
    .fill       (fill_r),
    .head       (head_r),
    .drop       (drop_r)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue with an in-order memory model and a PC scoreboard.
module tb_fetch_queue;
  localparam int              DEPTH  = 4;
  localparam int              ADDR_W = 16;
  localparam int              XLEN   = 32;
  localparam logic [XLEN-1:0] BOOT   = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_oe;
  logic              imem_ready;
  logic [31:0]       imem_rdata;
  logic              imem_valid;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [XLEN-1:0]   inst_pc;
  logic              inst_ready;
  logic [2:0]        occupancy;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .XLEN(XLEN), .BOOT(BOOT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_oe     (imem_oe),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    bit                stale;
    logic [ADDR_W-1:0] addr;
  } req_t;

  req_t            pend[$];
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_fpc;
  int              filled_cnt;
  int              checks = 0;
  int              errors = 0;
  int              cycle  = 0;
  int              fires  = 0;
  int              fb;
  int              p_ready, p_iready, p_valid, lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit redir, input logic [XLEN-1:0] rpc);
    int   stale_n;
    bit   fire, cons, arrive_fresh, exp_iv;
    logic [XLEN-1:0] epc;
    @(negedge clk);
    redirect    = redir;
    redirect_pc = rpc;
    imem_ready  = ($urandom_range(99) < p_ready);
    inst_ready  = ($urandom_range(99) < p_iready);
    imem_valid  = 1'b0;
    imem_rdata  = 32'h0;
    if (pend.size() > 0 && pend[0].due <= cycle && $urandom_range(99) < p_valid) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(pend[0].addr);
    end
    #1;
    stale_n = 0;
    foreach (pend[i]) if (pend[i].stale) stale_n++;
    arrive_fresh = 1'b0;
    if (imem_valid) arrive_fresh = !pend[0].stale;
    chk("imem_oe", imem_oe, !redir && (exp_q.size() + stale_n < DEPTH));
    chk("occupancy", occupancy, exp_q.size());
`ifdef FETCHQ_BYPASS_EN
    exp_iv = (filled_cnt > 0) || arrive_fresh;
`else
    exp_iv = (filled_cnt > 0);
`endif
    chk("inst_valid", inst_valid, exp_iv);
    fire = imem_oe && imem_ready;
    if (fire) chk("imem_addr", imem_addr, model_fpc[ADDR_W-1:0]);
    if (imem_valid) begin
      void'(pend.pop_front());
      if (arrive_fresh && !redir) filled_cnt++;
    end
    cons = inst_valid && inst_ready && !redir;
    if (cons) begin
      if (exp_q.size() == 0) begin
        chk("consume_on_empty", inst_valid, 0);
      end else begin
        epc = exp_q.pop_front();
        chk("inst_pc", inst_pc, epc);
        chk("inst", inst, mem_word(epc[ADDR_W-1:0]));
        filled_cnt--;
      end
    end
    if (fire) begin
      pend.push_back('{due: cycle + $urandom_range(lat_hi, lat_lo), stale: 1'b0, addr: model_fpc[ADDR_W-1:0]});
      exp_q.push_back(model_fpc);
      model_fpc = model_fpc + 32'd4;
      fires++;
    end
    if (redir) begin
      exp_q.delete();
      filled_cnt = 0;
      foreach (pend[i]) pend[i].stale = 1'b1;
      model_fpc = rpc & 32'hFFFF_FFFE;
    end
    cycle++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic set_cfg(input int r, input int ir, input int v, input int lo, input int hi);
    p_ready = r; p_iready = ir; p_valid = v; lat_lo = lo; lat_hi = hi;
  endtask

  task automatic clear_model();
    pend.delete();
    exp_q.delete();
    filled_cnt = 0;
    model_fpc  = BOOT;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_oe"}, imem_oe, 0);
    chk({tag, "_addr"}, imem_addr, BOOT[ADDR_W-1:0]);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0; redirect = 1'b0; imem_ready = 1'b0; imem_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    clear_model();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    imem_rdata = 32'h0; imem_valid = 1'b0; inst_ready = 1'b0;
    clear_model();
    #12;
    check_reset_outputs("por");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Streaming at L=1 with everything ready.
    set_cfg(100, 100, 100, 1, 1);
    run(12);

    // Decode stall: exactly DEPTH fires then the queue holds.
    do_reset();
    set_cfg(100, 0, 100, 1, 1);
    fb = fires;
    run(8);
    chk("stall_fires", fires - fb, DEPTH);
    chk("stall_occupancy", occupancy, DEPTH);
    set_cfg(100, 100, 100, 1, 1);
    run(2);
    chk("refill_fire", fires - fb, DEPTH + 1);
    run(6);

    // L=3 with requests in flight, then redirect to an odd target.
    set_cfg(100, 100, 100, 3, 3);
    run(6);
    step(1'b1, 32'h101);
    run(10);

    // Redirect while a response, a valid head and decode-ready coincide.
    set_cfg(100, 100, 100, 1, 1);
    run(6);
    step(1'b1, 32'h2000);
    run(8);

    // Random latency, backpressure and redirects.
    set_cfg(70, 70, 70, 1, 5);
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(99) < 2) step(1'b1, $urandom);
      else step(1'b0, 32'h0);
    end

    // Mid-stream reset with requests outstanding, then restart at BOOT.
    set_cfg(100, 0, 100, 3, 3);
    run(4);
    do_reset();
    set_cfg(100, 100, 100, 1, 2);
    run(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
